// File: rtl/imm_encoder.sv
// RISC-V immediate/field encoder for I, S and SB formats feeding a 2-entry
// output FIFO; requests that cannot be encoded become flagged NOPs.
module imm_encoder #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [63:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] ins,
    output logic        range_err,
    output logic [7:0]  err_count
);

    typedef enum logic [1:0] {
        FMT_I       = 2'd0,
        FMT_S       = 2'd1,
        FMT_SB      = 2'd2,
        FMT_ILLEGAL = 2'd3
    } fmt_e;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;
    // Only a two-entry buffer is supported, so pointers are a single bit.
    localparam logic [1:0]  FULL     = 2'(DEPTH);

    logic [1:0]  count;
    logic        wr_ptr;
    logic        rd_ptr;
    logic [31:0] mem_ins [2];
    logic [1:0]  mem_err;

    logic        push;
    logic        pop;
    logic        i_fits;
    logic        sb_fits;
    logic [31:0] enc_ins;
    logic        enc_err;

    // in_ready looks only at occupancy, never at out_ready.
    assign in_ready  = (count < FULL);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign ins       = out_valid ? mem_ins[rd_ptr] : 32'h0;
    assign range_err = out_valid && mem_err[rd_ptr];

    assign i_fits  = (imm[63:11] == '0) || (imm[63:11] == '1);
    assign sb_fits = ((imm[63:12] == '0) || (imm[63:12] == '1)) && !imm[0];

    always_comb begin
        enc_ins = NOP_WORD;
        enc_err = 1'b1;
        case (fmt_e'(fmt))
            FMT_I: begin
                if (i_fits) begin
                    enc_ins = {imm[11:0], rs1, funct3, rd, opcode};
                    enc_err = 1'b0;
                end
            end
            FMT_S: begin
                if (i_fits) begin
                    enc_ins = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                    enc_err = 1'b0;
                end
            end
            FMT_SB: begin
                if (sb_fits) begin
                    enc_ins = {imm[12], imm[10:5], rs2, rs1, funct3,
                               imm[4:1], imm[11], opcode};
                    enc_err = 1'b0;
                end
            end
            default: begin
                enc_ins = NOP_WORD;
                enc_err = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_ins[0] <= 32'h0;
            mem_ins[1] <= 32'h0;
            mem_err    <= 2'b00;
        end else if (push) begin
            mem_ins[wr_ptr] <= enc_ins;
            mem_err[wr_ptr] <= enc_err;
        end
    end

    // Saturates rather than wrapping so a long error burst stays visible.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_count <= 8'h00;
        end else if (push && enc_err && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'h01;
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed self-checking bench for imm_encoder: encodings, range limits,
// backpressure, ordering under push/pop, saturation and async reset.
module tb_imm_encoder;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ins;
    logic        range_err;
    logic [7:0]  err_count;

    int checks   = 0;
    int failures = 0;

    imm_encoder #(.DEPTH(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fmt       (fmt),
        .opcode    (opcode),
        .funct3    (funct3),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ins       (ins),
        .range_err (range_err),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] f, input logic [6:0] op, input logic [2:0] f3,
                                 input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                                 input logic [63:0] im);
        fmt = f; opcode = op; funct3 = f3; rd = d; rs1 = s1; rs2 = s2; imm = im;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push one request into an empty buffer, check the head, then pop it.
    task automatic runOne(input string tag, input logic [1:0] f, input logic [6:0] op,
                          input logic [2:0] f3, input logic [4:0] d, input logic [4:0] s1,
                          input logic [4:0] s2, input logic [63:0] im,
                          input logic [31:0] exp_ins, input logic exp_err, input logic [7:0] exp_cnt);
        applyStimulus(f, op, f3, d, s1, s2, im);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checkOutput({tag, "_valid"}, 64'(out_valid), 64'd1);
        checkOutput({tag, "_ins"}, 64'(ins), 64'(exp_ins));
        checkOutput({tag, "_err"}, 64'(range_err), 64'(exp_err));
        checkOutput({tag, "_cnt"}, 64'(err_count), 64'(exp_cnt));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput({tag, "_empty"}, 64'(out_valid), 64'd0);
    endtask

    logic [31:0] q[$];
    logic [31:0] word;
    logic [11:0] i12;
    logic [4:0]  rdv;
    logic [4:0]  rs1v;

    initial begin
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        applyStimulus(2'd0, 7'h13, 3'd0, 5'd0, 5'd0, 5'd0, 64'd0);
        repeat (3) tick();
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_ins", 64'(ins), 64'd0);
        checkOutput("rst_range_err", 64'(range_err), 64'd0);
        checkOutput("rst_err_count", 64'(err_count), 64'd0);
        reset = 1'b1;

        // Encodings and range boundaries
        runOne("i_neg1",   2'd0, 7'h13, 3'd0, 5'd5, 5'd6, 5'd0, -64'sd1,    32'hFFF30293, 1'b0, 8'd0);
        runOne("sb_16",    2'd2, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 64'd16,     32'h00208863, 1'b0, 8'd0);
        runOne("sb_17",    2'd2, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 64'd17,     32'h00000013, 1'b1, 8'd1);
        runOne("s_neg8",   2'd1, 7'h23, 3'd2, 5'd0, 5'd2, 5'd8, -64'sd8,    32'hFE812C23, 1'b0, 8'd1);
        runOne("i_2047",   2'd0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 64'd2047,   32'h7FF00093, 1'b0, 8'd1);
        runOne("i_2048",   2'd0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 64'd2048,   32'h00000013, 1'b1, 8'd2);
        runOne("i_m2048",  2'd0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, -64'sd2048, 32'h80000093, 1'b0, 8'd2);
        runOne("sb_4094",  2'd2, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 64'd4094,   32'h7E208FE3, 1'b0, 8'd2);
        runOne("sb_m4096", 2'd2, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, -64'sd4096, 32'h80208063, 1'b0, 8'd2);
        runOne("sb_4096",  2'd2, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 64'd4096,   32'h00000013, 1'b1, 8'd3);
        runOne("fmt3",     2'd3, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 64'd0,      32'h00000013, 1'b1, 8'd4);

        // Backpressure: A, B accepted; C held off until a slot frees
        applyStimulus(2'd0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 64'd1);
        in_valid = 1'b1;
        tick();
        applyStimulus(2'd0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 64'd2);
        tick();
        checkOutput("bp_full_ready", 64'(in_ready), 64'd0);
        applyStimulus(2'd0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 64'd3);
        tick();
        checkOutput("bp_hold_ready", 64'(in_ready), 64'd0);
        checkOutput("bp_head_a", 64'(ins), 64'h00100093);
        out_ready = 1'b1;
        #1;
        checkOutput("bp_ready_indep", 64'(in_ready), 64'd0);
        tick();
        checkOutput("bp_head_b", 64'(ins), 64'h00200093);
        checkOutput("bp_ready_after_pop", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        checkOutput("bp_head_c", 64'(ins), 64'h00300093);
        tick();
        out_ready = 1'b0;
        checkOutput("bp_drained", 64'(out_valid), 64'd0);

        // Simultaneous push/pop at occupancy 1
        applyStimulus(2'd0, 7'h13, 3'd0, 5'd7, 5'd3, 5'd0, 64'd100);
        q.push_back({12'd100, 5'd3, 3'd0, 5'd7, 7'h13});
        in_valid = 1'b1;
        tick();
        out_ready = 1'b1;
        for (int n = 0; n < 100; n++) begin
            i12  = 12'($urandom);
            rdv  = 5'($urandom_range(0, 31));
            rs1v = 5'($urandom_range(0, 31));
            applyStimulus(2'd0, 7'h13, 3'd0, rdv, rs1v, 5'd0, {{52{i12[11]}}, i12});
            word = {i12, rs1v, 3'd0, rdv, 7'h13};
            tick();
            void'(q.pop_front());
            q.push_back(word);
            checkOutput("pp_ins", 64'(ins), 64'(q[0]));
            checkOutput("pp_valid", 64'(out_valid), 64'd1);
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        checkOutput("pp_drained", 64'(out_valid), 64'd0);

        // Saturation: count already 4, reaches FF after 251 more errors
        applyStimulus(2'd3, 7'h13, 3'd0, 5'd0, 5'd0, 5'd0, 64'd0);
        in_valid = 1'b1;
        out_ready = 1'b1;
        repeat (250) tick();
        checkOutput("sat_254", 64'(err_count), 64'hFE);
        tick();
        checkOutput("sat_255", 64'(err_count), 64'hFF);
        repeat (49) tick();
        in_valid = 1'b0;
        checkOutput("sat_hold", 64'(err_count), 64'hFF);
        tick();
        out_ready = 1'b0;

        // Async reset with a full buffer
        applyStimulus(2'd0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 64'd5);
        in_valid = 1'b1;
        repeat (2) tick();
        in_valid = 1'b0;
        checkOutput("ar_full_valid", 64'(out_valid), 64'd1);
        checkOutput("ar_full_ready", 64'(in_ready), 64'd0);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("ar_valid", 64'(out_valid), 64'd0);
        checkOutput("ar_ready", 64'(in_ready), 64'd1);
        checkOutput("ar_err_count", 64'(err_count), 64'd0);
        checkOutput("ar_ins", 64'(ins), 64'd0);
        tick();
        reset = 1'b1;
        runOne("post_rst", 2'd0, 7'h13, 3'd0, 5'd5, 5'd6, 5'd0, -64'sd1, 32'hFFF30293, 1'b0, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
